// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and pipeline control outputs of the stall controller.
// The pipeline side holds the master modport, the controller the slave.
interface pipe_stall_ctrl_if #(
   parameter int CNT_BITS = 16
);
   logic [4:0]          dec_rs1;
   logic [4:0]          dec_rs2;
   logic                dec_uses_rs1;
   logic                dec_uses_rs2;
   logic                ex_is_load;
   logic [4:0]          ex_rd;
   logic                ex_mispredict;
   logic                mem_dmiss;
   logic                wb_exception;
   logic                pc_en;
   logic                en_fd;
   logic                en_de;
   logic                en_em;
   logic                en_mw;
   logic                flush_fd;
   logic                flush_de;
   logic                flush_em;
   logic                busy;
   logic [CNT_BITS-1:0] stall_cycles;

   modport master (
      output dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
      output ex_is_load, ex_rd, ex_mispredict,
      output mem_dmiss, wb_exception,
      input  pc_en, en_fd, en_de, en_em, en_mw,
      input  flush_fd, flush_de, flush_em,
      input  busy, stall_cycles
   );

   modport slave (
      input  dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
      input  ex_is_load, ex_rd, ex_mispredict,
      input  mem_dmiss, wb_exception,
      output pc_en, en_fd, en_de, en_em, en_mw,
      output flush_fd, flush_de, flush_em,
      output busy, stall_cycles
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Five-stage pipeline stall/flush controller: exceptions, D-cache
// miss freeze, branch mispredict flush, load-use bubble, stall counter.
module pipe_stall_ctrl #(
   parameter int MISS_LATENCY = 5,
   parameter int CNT_BITS     = 16
) (
   input logic              clk,
   input logic              reset,
   pipe_stall_ctrl_if.slave bus
);

   localparam logic [0:0] RUN       = 1'b0;
   localparam logic [0:0] MISS_WAIT = 1'b1;
   localparam logic [7:0] MISS_LOAD = 8'(MISS_LATENCY - 1);

   logic [0:0]          state;
   logic [0:0]          state_nxt;
   logic [7:0]          miss_cnt;
   logic [7:0]          cnt_nxt;
   logic [CNT_BITS-1:0] stall_q;
   logic                load_use;
   logic                rs1_hit;
   logic                rs2_hit;
   // {pc_en, en_fd, en_de, en_em, en_mw}
   logic [4:0]          en;
   // {flush_fd, flush_de, flush_em}
   logic [2:0]          fl;

   assign rs1_hit  = bus.dec_uses_rs1 && (bus.dec_rs1 == bus.ex_rd);
   assign rs2_hit  = bus.dec_uses_rs2 && (bus.dec_rs2 == bus.ex_rd);
   assign load_use = bus.ex_is_load && (bus.ex_rd != 5'd0)
                     && (rs1_hit || rs2_hit);

   always_comb begin
      en        = 5'b00000;
      fl        = 3'b000;
      state_nxt = state;
      cnt_nxt   = miss_cnt;
      if (reset) begin
         state_nxt = RUN;
         cnt_nxt   = 8'd0;
      end else if (bus.wb_exception) begin
         en        = 5'b11111;
         fl        = 3'b111;
         state_nxt = RUN;
         cnt_nxt   = 8'd0;
      end else if (state == MISS_WAIT) begin
         cnt_nxt = miss_cnt - 8'd1;
         if (miss_cnt <= 8'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 8'd0;
         end
      end else if (bus.mem_dmiss) begin
         // the detection cycle itself is the first frozen cycle
         state_nxt = MISS_WAIT;
         cnt_nxt   = MISS_LOAD;
      end else if (bus.ex_mispredict) begin
         en = 5'b11111;
         fl = 3'b110;
      end else if (load_use) begin
         en = 5'b00111;
         fl = 3'b010;
      end else begin
         en = 5'b11111;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         miss_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         miss_cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if (!en[4] && (stall_q != '1)) begin
         stall_q <= stall_q + CNT_BITS'(1);
      end
   end

   assign bus.pc_en        = en[4];
   assign bus.en_fd        = en[3];
   assign bus.en_de        = en[2];
   assign bus.en_em        = en[1];
   assign bus.en_mw        = en[0];
   assign bus.flush_fd     = fl[2];
   assign bus.flush_de     = fl[1];
   assign bus.flush_em     = fl[0];
   assign bus.busy         = (state == MISS_WAIT) && !reset;
   assign bus.stall_cycles = stall_q;

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MISS_LATENCY, default 5, giving total frozen cycles per D-cache miss; legal range 2..255.
REQ-002 SHALL have parameter CNT_BITS, default 16, giving the width of the stall-cycle performance counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports dec_rs1 and dec_rs2  input  5 each  source register numbers of the instruction in decode.
REQ-006 SHALL have ports dec_uses_rs1 and dec_uses_rs2  input  1 each  the decode instruction reads that source.
REQ-007 SHALL have ports ex_is_load  input  1 and ex_rd  input  5  the execute-stage load flag and its destination register.
REQ-008 SHALL have port ex_mispredict  input  1  branch in execute resolved against the fetch prediction.
REQ-009 SHALL have port mem_dmiss  input  1  D-cache miss detected in the memory stage; level, sampled only in RUN.
REQ-010 SHALL have port wb_exception  input  1  exception committing in writeback.
REQ-011 SHALL have ports pc_en, en_fd, en_de, en_em, en_mw  output  1 each  enables for the PC and the inter-stage pipeline registers.
REQ-012 SHALL have ports flush_fd, flush_de, flush_em  output  1 each  synchronous bubble-insert for the named pipeline register.
REQ-013 SHALL have port busy  output  1  high while in state MISS_WAIT.
REQ-014 SHALL have port stall_cycles  output  CNT_BITS  saturating count of cycles with pc_en low.

Function
REQ-015 SHALL implement two states, RUN and MISS_WAIT, plus a down-counter miss_cnt of 8 bits.
REQ-016 SHALL drive all control outputs combinationally from state, miss_cnt and the current inputs, with zero cycles of latency.
REQ-017 SHALL resolve conditions in the following priority order: wb_exception, then mem_dmiss or MISS_WAIT, then ex_mispredict, then load-use.
REQ-018 SHALL define load-use as: ex_is_load AND ex_rd != 0 AND ((dec_uses_rs1 AND dec_rs1 == ex_rd) OR (dec_uses_rs2 AND dec_rs2 == ex_rd)).
REQ-019 SHALL, on wb_exception in any state, drive pc_en=1, all en_*=1 and flush_fd=flush_de=flush_em=1, then set next state RUN and miss_cnt 0, aborting any miss wait.
REQ-020 SHALL, in RUN with mem_dmiss high, drive pc_en and all en_* to 0 and all flushes to 0, load miss_cnt with MISS_LATENCY-1, and set next state MISS_WAIT.
REQ-021 SHALL, in MISS_WAIT, drive pc_en and all en_* to 0 and all flushes to 0, and decrement miss_cnt.
REQ-022 SHALL leave MISS_WAIT for RUN on the edge where miss_cnt equals 1, so that exactly MISS_LATENCY consecutive cycles are frozen.
REQ-023 SHALL ignore mem_dmiss, ex_mispredict and load-use while in MISS_WAIT; the frozen stages re-present them after the wait.
REQ-024 SHALL, in RUN with ex_mispredict (no higher-priority condition), drive pc_en=1, all en_*=1, flush_fd=1, flush_de=1, flush_em=0.
REQ-025 SHALL, in RUN with load-use only, drive pc_en=0, en_fd=0, en_de=1 with flush_de=1 (one bubble), and en_em=en_mw=1, for exactly the cycles load-use holds.
REQ-026 SHALL, in RUN with no condition active, drive pc_en and all en_* to 1 and all flushes to 0.
REQ-027 SHALL increment stall_cycles on every edge where pc_en is 0 and reset is low, saturating at all-ones with no wrap.
REQ-028 SHALL treat ex_rd == 0 as never hazardous, even when a load targets r0.

Reset
REQ-029 SHALL, while reset is high, force state RUN, miss_cnt 0 and stall_cycles 0 asynchronously.
REQ-030 SHALL, while reset is high, drive pc_en, all en_*, all flush_* and busy to 0.
REQ-031 SHALL, when reset asserts mid-MISS_WAIT, abandon the wait immediately and resume in RUN with all outputs per REQ-026 on the first cycle after deassertion.

Verification
REQ-032 SHALL cover load-use: ex_is_load=1, ex_rd=7, dec_uses_rs2=1, dec_rs2=7 for one cycle -> pc_en=0, en_fd=0, flush_de=1 that cycle, and stall_cycles=1 after.
REQ-033 SHALL cover the r0 exclusion: the same stimulus with ex_rd=0 and dec_rs1=0 -> pc_en=1, with no flush asserted.
REQ-034 SHALL cover a D-cache miss: mem_dmiss pulsed 1 cycle with MISS_LATENCY=5 -> exactly 5 cycles of all-enables-low, busy high for 4 cycles, stall_cycles=5, then RUN.
REQ-035 SHALL cover simultaneous miss and mispredict: mem_dmiss and ex_mispredict in the same cycle -> freeze wins with no flush; the mispredict flush (flush_fd=flush_de=1) is applied on the first RUN cycle while ex_mispredict is held.
REQ-036 SHALL cover an exception mid-miss: wb_exception in the 3rd MISS_WAIT cycle -> all flushes 1 and pc_en=1 that cycle, busy=0 the next cycle.
REQ-037 SHALL cover reset and saturation: async reset mid-MISS_WAIT -> outputs 0 without a clock edge; with CNT_BITS=4 and 20 stall cycles -> stall_cycles=15.
